// File: rtl/tick_generator_bank_pkg.sv
// Shared constants and helpers for the tick generator bank.
// Optional feature macro: TICK_GEN_SQUARE_EN (adds per-channel square outputs).
package tick_generator_bank_pkg;

  // Boot-time periods in system clocks (100 MHz clock tree).
  localparam int unsigned EVERY_SECOND_DELAY = 100_000_000;
  localparam int unsigned SEND_DATA_DELAY    = 1_000_000;

  function automatic logic ch_valid(input int unsigned ch, input int unsigned channels);
    return ch < channels;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One programmable tick channel: period/enable/counter registers and tick pulse.
// Optional feature macro: TICK_GEN_SQUARE_EN (adds a 50% duty square bit).
module tick_channel #(
  parameter int              CNT_W          = 32,
  parameter logic [CNT_W-1:0] DEFAULT_PERIOD = CNT_W'(100),
  parameter logic            DEFAULT_EN     = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_period,
  input  logic             load_en,
  input  logic             sync,
  output logic             tick
`ifdef TICK_GEN_SQUARE_EN
  ,
  output logic             square
`endif
);

  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] cnt;
  logic             en;
  logic             active;

  // A zero period is treated exactly like a disabled channel.
  assign active = en && (period != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period <= DEFAULT_PERIOD;
      en     <= DEFAULT_EN;
      cnt    <= '0;
      tick   <= 1'b0;
`ifdef TICK_GEN_SQUARE_EN
      square <= 1'b0;
`endif
    end else if (load || sync) begin
      if (load) begin
        period <= load_period;
        en     <= load_en;
      end
      cnt  <= '0;
      tick <= 1'b0;
`ifdef TICK_GEN_SQUARE_EN
      square <= 1'b0;
`endif
    end else if (!active) begin
      cnt  <= '0;
      tick <= 1'b0;
`ifdef TICK_GEN_SQUARE_EN
      square <= 1'b0;
`endif
    end else if (cnt == period - CNT_W'(1)) begin
      cnt  <= '0;
      tick <= 1'b1;
`ifdef TICK_GEN_SQUARE_EN
      square <= ~square;
`endif
    end else begin
      cnt  <= cnt + CNT_W'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/tick_generator_bank.sv
// Bank of CHANNELS run-time programmable tick generators with global sync.
// Optional feature macro: TICK_GEN_SQUARE_EN (adds square[CHANNELS-1:0] output).
module tick_generator_bank
  import tick_generator_bank_pkg::*;
#(
  parameter int                  CHANNELS       = 4,
  parameter int                  CNT_W          = 32,
  parameter int                  CH_W           = 2,
  parameter logic [CNT_W-1:0]    DEFAULT_PERIOD = CNT_W'(100),
  parameter logic [CHANNELS-1:0] DEFAULT_EN     = {CHANNELS{1'b1}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic                cfg_en,
  input  logic                sync,
  output logic [CHANNELS-1:0] tick,
  output logic                cfg_err
`ifdef TICK_GEN_SQUARE_EN
  ,
  output logic [CHANNELS-1:0] square
`endif
);

  logic [CHANNELS-1:0] load;
  logic                cfg_valid;

  assign cfg_valid = ch_valid(32'(cfg_ch), 32'(CHANNELS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cfg_err <= 1'b0;
    else      cfg_err <= cfg_we && !cfg_valid;
  end

  // Out-of-range indices match no channel, so an invalid write touches nothing.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign load[i] = cfg_we && (cfg_ch == CH_W'(i));

    tick_channel #(
      .CNT_W         (CNT_W),
      .DEFAULT_PERIOD(DEFAULT_PERIOD),
      .DEFAULT_EN    (DEFAULT_EN[i])
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .load       (load[i]),
      .load_period(cfg_period),
      .load_en    (cfg_en),
      .sync       (sync),
      .tick       (tick[i])
`ifdef TICK_GEN_SQUARE_EN
      ,
      .square     (square[i])
`endif
    );
  end

endmodule
